// File: rtl/sram_mem_controller.sv
// sram_mem_controller
//   Services memory-stage loads/stores from an external 16-bit asynchronous
//   SRAM. Each 32-bit word is split into a low and a high half-word access,
//   each held for WAIT_CYCLES+1 cycles. `ready` drops in the request cycle
//   and stays low until DONE, freezing the pipeline.
// Ports:
//   clk, rst                 clock, async active-high reset
//   mem_r_en, mem_w_en       load / store request (store wins if both)
//   address, data            byte address and store data
//   mem_result               last loaded word (held across stores)
//   ready                    high when no access is pending
//   sram_addr                half-word address {word_idx, half}
//   sram_dq_out/in, _oe      SRAM data bus pieces; top level builds the inout
//   sram_we_n, sram_oe_n     active-low write strobe / output enable
module sram_mem_controller #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] data,
  output logic [31:0] mem_result,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  localparam logic [3:0] WMAX = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wcnt, wcnt_nxt;
  logic        op_wr;
  logic [16:0] idx;
  logic [31:0] wdata;
  logic [15:0] lo_buf;
  logic [31:0] offs;
  logic        req;
  logic        last;

  assign req  = mem_r_en | mem_w_en;
  assign last = (wcnt == WMAX);
  assign offs = address - BASE_ADDR;

  // ready is combinational so a new request freezes the pipeline at once
  assign ready = ((state == IDLE) && !req) || (state == DONE);

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      IDLE: if (req) begin
        state_nxt = LO;
        wcnt_nxt  = '0;
      end
      LO: if (last) begin
        state_nxt = HI;
        wcnt_nxt  = '0;
      end else wcnt_nxt = wcnt + 4'd1;
      HI: if (last) begin
        state_nxt = DONE;
        wcnt_nxt  = '0;
      end else wcnt_nxt = wcnt + 4'd1;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wcnt       <= '0;
      op_wr      <= 1'b0;
      idx        <= '0;
      wdata      <= '0;
      lo_buf     <= '0;
      mem_result <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      // operation, address and data are frozen at the request cycle
      if (state == IDLE && req) begin
        op_wr <= mem_w_en;
        idx   <= offs[18:2];
        wdata <= data;
      end
      if (state == LO && last && !op_wr) lo_buf <= sram_dq_in;
      if (state == HI && last && !op_wr) mem_result <= {sram_dq_in, lo_buf};
    end
  end

  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    if (state == LO || state == HI) begin
      sram_addr = {idx, state == HI};
      if (op_wr) begin
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state == HI) ? wdata[31:16] : wdata[15:0];
        // last cycle of a phase releases the strobe so data is held past it;
        // with no wait cycles the single cycle must carry the strobe
        sram_we_n   = last && (WAIT_CYCLES != 0);
      end else begin
        sram_oe_n = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
module tb_sram_mem_controller;
  localparam int          W    = 1;
  localparam int          P    = W + 1;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] address, data;
  logic [31:0] mem_result;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  always #5 clk = ~clk;

  sram_mem_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .address(address), .data(data), .mem_result(mem_result), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  // external SRAM: writes while strobe low and bus driven, reads when enabled
  logic [15:0] sram [0:262143];
  always @(posedge clk) if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;
  assign sram_dq_in = !sram_oe_n ? sram[sram_addr] : 16'hFFFF;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // word-level reference: each request occupies 2*P busy cycles after the
  // request cycle, then one DONE cycle where the word op takes effect
  bit [31:0] ref_mem [bit [16:0]];
  bit        busy = 0;
  int        m_cnt;
  bit        m_wr;
  bit [16:0] m_idx;
  bit [31:0] m_data;
  bit [31:0] exp_res = 0;

  task automatic check_idle_outs(input string tag);
    check({tag, "_we_n"}, sram_we_n, 1);
    check({tag, "_oe_n"}, sram_oe_n, 1);
    check({tag, "_dq_oe"}, sram_dq_oe, 0);
    check({tag, "_addr"}, sram_addr, 0);
    check({tag, "_dq_out"}, sram_dq_out, 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      busy = 0;
      exp_res = 0;
      check("rst_ready", ready, !(mem_r_en | mem_w_en));
      check("rst_mem_result", mem_result, 0);
      check_idle_outs("rst");
    end else if (!busy) begin
      check("idle_ready", ready, !(mem_r_en | mem_w_en));
      check("idle_mem_result", mem_result, exp_res);
      check_idle_outs("idle");
      if (mem_r_en | mem_w_en) begin
        busy   = 1;
        m_cnt  = 1;
        m_wr   = mem_w_en;
        m_idx  = 17'((address - BASE) >> 2);
        m_data = data;
      end
    end else if (m_cnt <= 2 * P) begin
      int half, pos;
      half = (m_cnt - 1) / P;
      pos  = (m_cnt - 1) % P;
      check("busy_ready", ready, 0);
      check("busy_mem_result", mem_result, exp_res);
      check("busy_addr", sram_addr, {m_idx, half[0]});
      if (m_wr) begin
        check("wr_oe_n", sram_oe_n, 1);
        check("wr_dq_oe", sram_dq_oe, 1);
        check("wr_dq_out", sram_dq_out, half ? m_data[31:16] : m_data[15:0]);
        check("wr_we_n", sram_we_n, (W != 0) && (pos == W));
      end else begin
        check("rd_oe_n", sram_oe_n, 0);
        check("rd_dq_oe", sram_dq_oe, 0);
        check("rd_we_n", sram_we_n, 1);
      end
      m_cnt++;
    end else begin
      if (m_wr) ref_mem[m_idx] = m_data;
      else exp_res = ref_mem.exists(m_idx) ? ref_mem[m_idx] : 32'h0;
      check("done_ready", ready, 1);
      check("done_mem_result", mem_result, exp_res);
      check_idle_outs("done");
      busy = 0;
    end
  end

  task automatic do_req(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                        output int rdy_low, output int we_low);
    bit done;
    @(posedge clk); #1;
    mem_w_en = w; mem_r_en = r; address = a; data = d;
    rdy_low = 0; we_low = 0; done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (!sram_we_n) we_low++;
      if (!ready) rdy_low++;
      else done = 1;
    end
    check("req_completes", done, 1);
  endtask

  task automatic go_idle(input int n);
    @(posedge clk); #1;
    mem_w_en = 0; mem_r_en = 0;
    repeat (n - 1) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rl, wl;
    for (int i = 0; i < 262144; i++) sram[i] = 16'h0;
    mem_r_en = 0; mem_w_en = 0; address = 0; data = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_ready", ready, 1);
    check("reset_we_n", sram_we_n, 1);
    check("reset_oe_n", sram_oe_n, 1);
    check("reset_mem_result", mem_result, 0);

    // store then load back
    do_req(1, 0, 32'd1024, 32'hDEADBEEF, rl, wl);
    check("store_ready_low", rl, 5);
    check("store_we_low", wl, 2);
    go_idle(2);
    check("store_sram0", sram[0], 16'hBEEF);
    check("store_sram1", sram[1], 16'hDEAD);
    do_req(0, 1, 32'd1024, 32'h0, rl, wl);
    check("load_result", mem_result, 32'hDEADBEEF);
    check("load_ready_low", rl, 5);
    check("load_we_low", wl, 0);

    // address mapping
    do_req(1, 0, 32'd1032, 32'h12345678, rl, wl);
    go_idle(2);
    check("map_sram4", sram[4], 16'h5678);
    check("map_sram5", sram[5], 16'h1234);
    do_req(0, 1, 32'd1032, 32'h0, rl, wl);
    check("map_load", mem_result, 32'h12345678);

    // write priority, then back-to-back load
    do_req(1, 1, 32'd1028, 32'hA5A5A5A5, rl, wl);
    check("prio_result_kept", mem_result, 32'h12345678);
    check("prio_we_low", wl, 2);
    do_req(0, 1, 32'd1028, 32'h0, rl, wl);
    check("b2b_load", mem_result, 32'hA5A5A5A5);
    check("b2b_ready_low", rl, 5);
    check("b2b_sram2", sram[2], 16'hA5A5);

    // reset in the second LO cycle of a load
    go_idle(1);
    @(posedge clk); #1;
    mem_r_en = 1; address = 32'd1024;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1; mem_r_en = 0;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_mem_result", mem_result, 0);
    check("midrst_oe_n", sram_oe_n, 1);
    @(posedge clk); #1 rst = 0;
    do_req(0, 1, 32'd1024, 32'h0, rl, wl);
    check("after_rst_load", mem_result, 32'hDEADBEEF);

    // randomized traffic, mostly in a small window plus wrapped addresses
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      int op;
      op = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) a = $urandom();
      else a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      do_req(op != 1, op != 0, a, $urandom(), rl, wl);
      check("rand_ready_low", rl, 2 * P + 1);
      if ($urandom_range(0, 2) == 0) go_idle($urandom_range(1, 3));
    end
    go_idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_mem_controller.md
# sram_mem_controller

Multi-cycle controller that services the memory stage's load/store requests from an external 16-bit asynchronous SRAM instead of an on-chip register array. It sits directly behind the memory stage, taking the EX/MEM address and store data. Each 32-bit word is split into two 16-bit SRAM accesses. While an access is in flight, `ready` is held low so the pipeline freezes.

## Interface
- `WAIT_CYCLES`, default 1: extra cycles each SRAM half-access is held (0–15).
- `BASE_ADDR`, default 32'd1024: byte address mapped to SRAM word 0.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `mem_r_en` in 1: load request, from EX/MEM register.
- `mem_w_en` in 1: store request, from EX/MEM register.
- `address` in 32: byte address of the access.
- `data` in 32: store data.
- `mem_result` out 32: load result to MEM/WB register.
- `ready` out 1: high when no access is pending; low freezes all pipeline registers.
- `sram_addr` out 18: SRAM half-word address.
- `sram_dq_out` out 16: write data driven to SRAM.
- `sram_dq_in` in 16: data read from SRAM.
- `sram_dq_oe` out 1: tri-state enable for `sram_dq_out`; the top level builds the inout.
- `sram_we_n` out 1: SRAM write strobe, active-low.
- `sram_oe_n` out 1: SRAM output enable, active-low.

## Operation
- Address mapping: `word_idx = (address - BASE_ADDR) >> 2`, truncated to 17 bits; out-of-range addresses wrap, with no error flag.
- Low half-word: `sram_addr = {word_idx, 1'b0}`, carrying `data[15:0]`.
- High half-word: `sram_addr = {word_idx, 1'b1}`, carrying `data[31:16]`.
- FSM states: IDLE, LO, HI, DONE. A cycle counter `wcnt` runs 0..WAIT_CYCLES.
- IDLE: if `mem_w_en | mem_r_en`, latch the operation type and go to LO with `wcnt = 0`. Write wins if both are high.
- LO / HI: SRAM address is held for WAIT_CYCLES+1 cycles. When `wcnt == WAIT_CYCLES`, clear `wcnt` and advance: LO→HI, HI→DONE.
- DONE: one cycle, then IDLE unconditionally.
- Read phases: `sram_oe_n = 0`, `sram_dq_oe = 0`.
  - On the last cycle of LO, capture `sram_dq_in` into `lo_buf`.
  - On the last cycle of HI, load `mem_result <= {sram_dq_in, lo_buf}`.
- Write phases: `sram_we_n = 0` and `sram_dq_oe = 1` for the whole phase, except the last cycle of each phase, when `sram_we_n = 1` (data-hold cycle).
  - When WAIT_CYCLES = 0, `sram_we_n` is low for the single cycle of each phase.
- Idle values: `sram_we_n = 1`, `sram_oe_n = 1`, `sram_dq_oe = 0`, `sram_addr = 0`, `sram_dq_out = 0`.
- `ready`: `(state == IDLE && !(mem_r_en | mem_w_en)) || state == DONE`. This is combinational, because the request must freeze the pipeline in the same cycle it appears.
- `mem_result` holds its last loaded value. A store never changes it. It is not gated by `mem_r_en`.
- Request inputs are assumed stable while `ready = 0`, since the pipeline is frozen. Changes to the inputs in LO or HI are ignored, because the address, data and operation were latched in IDLE.

## Timing
- Reset values: state IDLE, `wcnt = 0`, `mem_result = 0`, `lo_buf = 0`, all SRAM outputs at their idle values, `ready = 1` while no request is asserted.
- Latency from the request cycle (IDLE) to DONE is 2·(WAIT_CYCLES+1)+1 cycles. With WAIT_CYCLES = 1 this is 5 cycles: IDLE, LO, LO, HI, HI, DONE.
- `mem_result` is valid in the DONE cycle; the MEM/WB register captures it at the end of DONE.
- A new request seen in the IDLE cycle directly after DONE starts a fresh access. There are no dead cycles beyond DONE.
- Reset asserted mid-access returns to IDLE immediately.
  - `mem_result` keeps its reset value of 0.
  - A partially written word may remain in SRAM; this is acceptable.
- With no request, the block stays in IDLE and makes no SRAM activity.

## Test plan
- **Reset idle:** hold `rst` high 3 cycles, then release with no request → `ready = 1`, `sram_we_n = sram_oe_n = 1`, `mem_result = 0`, state IDLE.
- **Store:** WAIT_CYCLES = 1, `mem_w_en = 1`, `address = 1024`, `data = 32'hDEADBEEF`.
  - `ready` is low for 5 cycles and high in the 6th (DONE).
  - SRAM model holds `[0] = 16'hBEEF` and `[1] = 16'hDEAD`.
  - `sram_we_n` is low exactly 1 cycle per phase.
- **Load back:** `mem_r_en = 1`, `address = 1024` after the store → `mem_result = 32'hDEADBEEF` in the DONE cycle; SRAM is not written.
- **Address mapping:** store `32'h12345678` at `address = 1032` → SRAM halves `[4] = 16'h5678`, `[5] = 16'h1234`. A load from 1032 returns `32'h12345678`.
- **Priority and back-to-back:**
  - Both enables high, `address = 1028`, `data = 32'hA5A5A5A5` → the access is a write and `mem_result` is unchanged.
  - A load from 1028 issued the cycle after DONE completes with no extra idle cycle and returns `32'hA5A5A5A5`.
- **Reset mid-operation:** assert `rst` in the second LO cycle of a load → IDLE at once, `ready = 1`, `mem_result = 0`, `sram_oe_n = 1`. A subsequent load completes normally.
